// File: rtl/fetch_sequencer_pkg.sv
// ============================================================================
// Module      : fetch_sequencer_pkg
// Description : Shared constants and state encoding for the fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_sequencer_pkg;

  localparam int          c_XLEN         = 32;
  localparam logic [31:0] c_RESET_VECTOR = 32'h0000_0000;
  localparam int          c_INSTR_W      = 32;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_fifo.sv
// ============================================================================
// Module      : fetch_fifo
// Description : Power-of-two synchronous FIFO with flush and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (c_AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      r_count <= r_count + (c_AW+1)'(w_push) - (c_AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module      : fetch_sequencer
// Description : In-order instruction fetch with redirect/drain handling.
//               Optional FETCH_MISALIGN_TRAP_EN adds o_misalign_trap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              XLEN         = c_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(c_RESET_VECTOR),
  parameter int              BUF_DEPTH    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 o_imem_req_valid,
  input  logic                 i_imem_req_ready,
  output logic [XLEN-1:0]      o_imem_req_addr,
  input  logic                 i_imem_rsp_valid,
  input  logic [c_INSTR_W-1:0] i_imem_rsp_data,
  output logic                 o_instr_valid,
  input  logic                 i_instr_ready,
  output logic [c_INSTR_W-1:0] o_instr_data,
  output logic [XLEN-1:0]      o_instr_pc,
  input  logic                 i_redirect_valid,
  input  logic [XLEN-1:0]      i_redirect_target
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                 o_misalign_trap
`endif
);

  localparam int c_CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e                  r_state;
  fetch_state_e                  w_state_next;
  logic [XLEN-1:0]               r_pc;
  logic [XLEN-1:0]               r_rsp_pc;
  logic [c_CW-1:0]               r_outstanding;
  logic                          r_req_valid;
  logic [c_CW-1:0]               w_out_next;
  logic [c_CW-1:0]               w_cnt_next;
  logic                          w_req_fire;
  logic                          w_rsp_acc;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_redir;
  logic                          w_halt_next;
  logic [XLEN-1:0]               w_target;
  logic [XLEN+c_INSTR_W-1:0]     w_fifo_data;
  logic                          w_fifo_full;
  logic                          w_fifo_empty;
  logic [c_CW-1:0]               w_fifo_count;

  // Responses with nothing outstanding (e.g. stale ones after reset) are ignored.
  assign w_req_fire = r_req_valid & i_imem_req_ready;
  assign w_rsp_acc  = i_imem_rsp_valid & (r_outstanding != '0);
  assign w_pop      = o_instr_valid & i_instr_ready;
  assign w_target   = i_redirect_target & ~XLEN'(3);
  assign w_push     = w_rsp_acc & (r_state == ST_RUN) & ~w_redir & ~w_fifo_full;
  assign w_out_next = r_outstanding + c_CW'(w_req_fire) - c_CW'(w_rsp_acc);
  assign w_cnt_next = w_redir ? '0 : (w_fifo_count + c_CW'(w_push) - c_CW'(w_pop));

`ifdef FETCH_MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_halt;
  logic r_trap;

  assign w_misalign      = i_redirect_valid & (i_redirect_target[1:0] != 2'b00);
  assign w_redir         = i_redirect_valid & ~w_misalign;
  assign w_halt_next     = w_misalign | (r_halt & ~w_redir);
  assign o_misalign_trap = r_trap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halt <= 1'b0;
      r_trap <= 1'b0;
    end else begin
      r_halt <= w_halt_next;
      r_trap <= w_misalign;
    end
  end
`else
  assign w_redir     = i_redirect_valid;
  assign w_halt_next = 1'b0;
`endif

  // In DRAIN nothing new is issued, so the outstanding count is the drop count.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (w_redir && (w_out_next != '0)) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_out_next == '0) w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_VECTOR;
      r_rsp_pc      <= RESET_VECTOR;
      r_outstanding <= '0;
      r_req_valid   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_out_next;
      r_req_valid   <= (w_state_next == ST_RUN) && !w_halt_next &&
                       (({1'b0, w_out_next} + {1'b0, w_cnt_next}) < (c_CW+1)'(BUF_DEPTH));
      if (w_redir) begin
        r_pc     <= w_target;
        r_rsp_pc <= w_target;
      end else begin
        if (w_req_fire) r_pc     <= r_pc + XLEN'(4);
        if (w_push)     r_rsp_pc <= r_rsp_pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (XLEN + c_INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({r_rsp_pc, i_imem_rsp_data}),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign o_imem_req_valid = r_req_valid;
  assign o_imem_req_addr  = r_pc;
  assign o_instr_valid    = ~w_fifo_empty;
  assign o_instr_data     = o_instr_valid ? w_fifo_data[c_INSTR_W-1:0] : '0;
  assign o_instr_pc       = o_instr_valid ? w_fifo_data[XLEN+c_INSTR_W-1:c_INSTR_W] : '0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Self-checking bench for fetch_sequencer with a 1-cycle memory
//               model; FETCH_MISALIGN_TRAP_EN enables the trap scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  logic        mem_hold = 1'b0;
  logic        inject_stray = 1'b0;
  logic [31:0] pend_q[$];
  logic [31:0] req_log[$];
  logic [31:0] dec_pc_log[$];
  logic [31:0] dec_data_log[$];
  logic [31:0] exp_pc_q[$];
  int          checks = 0;
  int          errors = 0;

  fetch_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .o_imem_req_valid  (req_valid),
    .i_imem_req_ready  (req_ready),
    .o_imem_req_addr   (req_addr),
    .i_imem_rsp_valid  (rsp_valid),
    .i_imem_rsp_data   (rsp_data),
    .o_instr_valid     (instr_valid),
    .i_instr_ready     (instr_ready),
    .o_instr_data      (instr_data),
    .o_instr_pc        (instr_pc),
    .i_redirect_valid  (redirect_valid),
    .i_redirect_target (redirect_target)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .o_misalign_trap   (misalign_trap)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h1357_9BDF;
  endfunction

  // Memory: answers each accepted request one cycle later, in order.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      pend_q.delete();
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end else if (inject_stray) begin
      rsp_valid = 1'b1;
      rsp_data  = 32'hBAD0_BAD0;
    end else if (!mem_hold && pend_q.size() > 0) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(pend_q.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end
  end

  // Handshake monitor: inputs settle by negedge+1, so negedge+2 shows the next edge.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (req_valid && req_ready) begin
        pend_q.push_back(req_addr);
        req_log.push_back(req_addr);
      end
      if (instr_valid && instr_ready) begin
        dec_pc_log.push_back(instr_pc);
        dec_data_log.push_back(instr_data);
      end
    end
  end

  task automatic do_reset(input logic rq_rdy, input logic dec_rdy, input logic hold);
    @(negedge clk);
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    req_ready = rq_rdy; instr_ready = dec_rdy; mem_hold = hold; inject_stray = 1'b0;
    repeat (2) @(negedge clk);
    req_log.delete(); dec_pc_log.delete(); dec_data_log.delete(); exp_pc_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_dec(output bit ok, output logic [31:0] pc, output logic [31:0] data);
    int n = 0;
    ok = 1'b0; pc = '0; data = '0;
    while (dec_pc_log.size() == 0 && n < 60) begin
      @(negedge clk); #3; n++;
    end
    if (dec_pc_log.size() > 0) begin
      pc = dec_pc_log.pop_front(); data = dec_data_log.pop_front(); ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req_ready = 1'b0; instr_ready = 1'b0; mem_hold = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL reset_instr_data: got %h want 0", instr_data); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b want 1", req_valid); end
    checks++; if (req_addr !== 32'h0) begin errors++; $display("FAIL first_req_addr: got %h want 0", req_addr); end
  endtask

  task automatic test_basic_stream();
    bit ok; logic [31:0] pc, data, exp;
    do_reset(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) exp_pc_q.push_back(32'(i * 4));
    for (int i = 0; i < 4; i++) begin
      wait_dec(ok, pc, data);
      exp = exp_pc_q.pop_front();
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_timeout: no decode, want pc %h", exp); end
      else if (pc !== exp) begin errors++; $display("FAIL basic_pc: got %h want %h", pc, exp); end
      checks++;
      if (ok && data !== mem_word(exp)) begin errors++; $display("FAIL basic_data: got %h want %h", data, mem_word(exp)); end
    end
    checks++;
    if (req_log.size() < 3) begin errors++; $display("FAIL basic_req_count: got %0d want >=3", req_log.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (req_log[i] !== 32'(i * 4)) begin errors++; $display("FAIL basic_req_addr: got %h want %h", req_log[i], 32'(i * 4)); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    #3;
    checks++; if (req_log.size() != 2) begin errors++; $display("FAIL bp_req_count: got %0d want 2", req_log.size()); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b want 0", req_valid); end
    @(negedge clk); instr_ready = 1'b1;
    @(negedge clk); instr_ready = 1'b0;
    repeat (6) @(negedge clk);
    #3;
    checks++; if (req_log.size() != 3) begin errors++; $display("FAIL bp_req_after_pop: got %0d want 3", req_log.size()); end
    checks++;
    if (dec_pc_log.size() != 1) begin errors++; $display("FAIL bp_pop_count: got %0d want 1", dec_pc_log.size()); end
    else if (dec_pc_log[0] !== 32'h0) begin errors++; $display("FAIL bp_pop_pc: got %h want 0", dec_pc_log[0]); end
  endtask

  task automatic test_redirect_drain();
    bit ok; logic [31:0] pc, data, exp;
    do_reset(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20 && req_log.size() < 2; i++) begin @(negedge clk); #3; end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_target = 32'h100;
    exp_pc_q.push_back(32'h100); exp_pc_q.push_back(32'h104);
    @(negedge clk);
    redirect_valid = 1'b0; mem_hold = 1'b0;
    #3;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL drain_req_valid: got %b want 0", req_valid); end
    for (int i = 0; i < 2; i++) begin
      wait_dec(ok, pc, data);
      exp = exp_pc_q.pop_front();
      checks++;
      if (!ok || pc !== exp) begin errors++; $display("FAIL drain_pc: got %h (ok=%b) want %h", pc, ok, exp); end
    end
  endtask

  task automatic test_wrap();
    bit ok; logic [31:0] pc, data, exp;
    do_reset(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFF8;
    exp_pc_q.push_back(32'hFFFF_FFF8); exp_pc_q.push_back(32'hFFFF_FFFC);
    exp_pc_q.push_back(32'h0000_0000); exp_pc_q.push_back(32'h0000_0004);
    @(negedge clk);
    redirect_valid = 1'b0; req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_dec(ok, pc, data);
      exp = exp_pc_q.pop_front();
      checks++;
      if (!ok || pc !== exp) begin errors++; $display("FAIL wrap_pc: got %h (ok=%b) want %h", pc, ok, exp); end
    end
    checks++;
    if (req_log.size() < 3) begin errors++; $display("FAIL wrap_req_count: got %0d want >=3", req_log.size()); end
    else if (req_log[2] !== 32'h0) begin errors++; $display("FAIL wrap_req_addr: got %h want 0", req_log[2]); end
  endtask

  task automatic test_redirect_on_pop();
    bit ok, found; logic [31:0] pc, data, exp;
    do_reset(1'b1, 1'b1, 1'b0);
    exp_pc_q.push_back(32'h0); exp_pc_q.push_back(32'h4); exp_pc_q.push_back(32'h8);
    exp_pc_q.push_back(32'h200); exp_pc_q.push_back(32'h204);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (instr_valid && instr_pc == 32'h8) begin
        found = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL pop_redir_setup: pc 8 seen %b want 1", found); end
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_dec(ok, pc, data);
      exp = exp_pc_q.pop_front();
      checks++;
      if (!ok || pc !== exp) begin errors++; $display("FAIL pop_redir_pc: got %h (ok=%b) want %h", pc, ok, exp); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [31:0] pc, data;
    do_reset(1'b1, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0; mem_hold = 1'b0;
    repeat (2) @(negedge clk);
    req_log.delete(); dec_pc_log.delete(); dec_data_log.delete();
    rst_n = 1'b1; inject_stray = 1'b1;
    @(negedge clk);
    inject_stray = 1'b0;
    wait_dec(ok, pc, data);
    checks++; if (!ok || pc !== 32'h0) begin errors++; $display("FAIL midrst_pc: got %h (ok=%b) want 0", pc, ok); end
    checks++; if (data !== mem_word(32'h0)) begin errors++; $display("FAIL midrst_data: got %h want %h", data, mem_word(32'h0)); end
  endtask

`ifdef FETCH_MISALIGN_TRAP_EN
  task automatic test_misalign_trap();
    bit ok; logic [31:0] pc, data;
    do_reset(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_target = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0; req_ready = 1'b1; #1;
    checks++; if (misalign_trap !== 1'b1) begin errors++; $display("FAIL trap_pulse: got %b want 1", misalign_trap); end
    @(negedge clk); #1;
    checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL trap_clear: got %b want 0", misalign_trap); end
    repeat (5) @(negedge clk);
    #3;
    checks++; if (req_log.size() != 0) begin errors++; $display("FAIL trap_no_req: got %0d want 0", req_log.size()); end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_target = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_dec(ok, pc, data);
    checks++; if (!ok || pc !== 32'h300) begin errors++; $display("FAIL trap_resume_pc: got %h (ok=%b) want 300", pc, ok); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_redirect_drain();
    test_wrap();
    test_redirect_on_pop();
    test_reset_mid();
`ifdef FETCH_MISALIGN_TRAP_EN
    test_misalign_trap();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter XLEN, default 32, PC and address width.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter BUF_DEPTH, default 2, maximum in-flight plus buffered instructions (power of two, 2..8).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 imem_req_valid  output  1  fetch request valid.
REQ-007 imem_req_ready  input  1  memory accepts request.
REQ-008 imem_req_addr  output  XLEN  word-aligned fetch address.
REQ-009 imem_rsp_valid  input  1  in-order instruction response valid, no backpressure.
REQ-010 imem_rsp_data  input  32  instruction word.
REQ-011 instr_valid  output  1  instruction available to decode.
REQ-012 instr_ready  input  1  decode accepts instruction.
REQ-013 instr_data  output  32  instruction word.
REQ-014 instr_pc  output  XLEN  PC of instr_data.
REQ-015 redirect_valid  input  1  one-cycle redirect (JAL, JALR, taken branch).
REQ-016 redirect_target  input  XLEN  new PC.

Function
REQ-017 Request handshake SHALL complete when imem_req_valid and imem_req_ready are high on the same edge; fetch PC then advances by 4, modulo 2^XLEN (0xFFFF_FFFC wraps to 0).
REQ-018 imem_req_valid SHALL be high only in state RUN and when outstanding + buffered < BUF_DEPTH; imem_req_addr SHALL hold stable while valid and not ready.
REQ-019 Responses SHALL enter a FIFO of BUF_DEPTH entries with their PCs; instr_valid SHALL rise the cycle after the accepted imem_rsp_valid (one-cycle latency).
REQ-020 Decode handshake completes when instr_valid and instr_ready are high; FIFO pops; instr_data/instr_pc SHALL hold while instr_valid and not instr_ready.
REQ-021 Request, response and decode pop in the same cycle SHALL all take effect; counters stay consistent, FIFO never overflows.
REQ-022 States: RUN, DRAIN. RUN -> DRAIN on redirect_valid with outstanding requests > 0 (counting one accepted that cycle); RUN -> RUN on redirect with none outstanding; DRAIN -> RUN when drop count reaches 0.
REQ-023 On redirect_valid: fetch PC := redirect_target next cycle, FIFO flushed, instr_valid low next cycle, drop count := outstanding requests.
REQ-024 In DRAIN, each imem_rsp_valid SHALL decrement drop count and be discarded; no new requests issued.
REQ-025 Redirect coincident with a decode handshake: handshake completes, then flush; redirect coincident with a response: response discarded.
REQ-026 Redirect while in DRAIN SHALL update fetch PC to the newest target and keep the drop count.
REQ-027 redirect_target bits [1:0] SHALL be ignored for addressing (forced to 0) unless REQ-031 applies.

Reset
REQ-028 On reset low: state RUN, fetch PC := RESET_VECTOR, FIFO empty, counters 0, imem_req_valid 0, instr_valid 0, instr_data 0, instr_pc 0.
REQ-029 Reset asserted mid-operation SHALL abandon in-flight requests; responses arriving after release without a matching request SHALL be ignored.
REQ-030 First request SHALL be issued the first cycle after reset deasserts.

Configuration
REQ-031 FETCH_MISALIGN_TRAP_EN defined: extra output misalign_trap (1 bit) pulses one cycle when redirect_target[1:0] != 0; redirect ignored, fetch stops until next valid redirect. Undefined: no port, REQ-027 applies.

Structure
REQ-032 Shared package holds XLEN default, RESET_VECTOR, state encoding (RUN, DRAIN), instruction width constant.
REQ-033 One sub-module fetch_fifo (parametrised depth/width, push, pop, flush, full/empty, count).

Verification
REQ-034 Reset release, imem_req_ready=1, 1-cycle memory -> addresses 0x0,0x4,0x8 issued; instr_pc 0x0,0x4,0x8 in order.
REQ-035 instr_ready=0, BUF_DEPTH=2 -> exactly 2 requests issued, then imem_req_valid low until a pop.
REQ-036 Redirect to 0x100 with 2 outstanding -> DRAIN, 2 responses dropped, next instr_pc 0x100.
REQ-037 Fetch PC 0xFFFF_FFFC -> next request address 0x0.
REQ-038 Redirect same cycle as decode handshake at pc 0x8 -> 0x8 consumed once, next delivered pc = target.
REQ-039 FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> misalign_trap one-cycle pulse, no request to 0x100/0x102.
